// File: rtl/random_arbiter.sv
// Round-robin distributor: each accepted upstream random word is offered to exactly one consumer.
// Define RANDOM_ARBITER_COUNT_EN to build saturating per-port delivery counters.
module random_arbiter #(
    parameter int PORTS = 4,
    parameter int BITS  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITS-1:0]     in_data,
    input  logic [PORTS-1:0]    req,
    output logic [PORTS-1:0]    out_valid,
    output logic [BITS-1:0]     out_data,
    output logic [PORTS*16-1:0] count_flat
);
    localparam int PW = $clog2(PORTS);
    localparam logic [PW-1:0] LAST = PW'(PORTS - 1);

    typedef enum logic [1:0] {StEmpty, StArb, StOffer} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   grant_q, grant_d;
    logic [PW-1:0]   pick;
    logic [BITS-1:0] hold_q, hold_d;
    logic            found;
    logic            done;
    int              idx;

    // First requester at or after ptr, wrapping past the top port.
    always_comb begin
        pick  = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < PORTS; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= PORTS) idx = idx - PORTS;
            if (!found && req[idx[PW-1:0]]) begin
                found = 1'b1;
                pick  = idx[PW-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        hold_d    = hold_q;
        done      = 1'b0;
        in_ready  = 1'b0;
        out_valid = '0;
        unique case (state_q)
            StEmpty: begin
                in_ready = !rst;
                if (in_valid) begin
                    hold_d  = in_data;
                    state_d = StArb;
                end
            end
            StArb: begin
                if (found) begin
                    grant_d = pick;
                    state_d = StOffer;
                end
            end
            StOffer: begin
                out_valid[grant_q] = 1'b1;
                // The offer is held for the granted port only; other requests are ignored.
                done = req[grant_q];
                if (done) begin
                    ptr_d   = (grant_q == LAST) ? '0 : grant_q + 1'b1;
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
            ptr_q   <= '0;
            grant_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            hold_q  <= hold_d;
        end
    end

    assign out_data = hold_q;

`ifdef RANDOM_ARBITER_COUNT_EN
    logic [15:0] cnt_q [PORTS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < PORTS; p++) cnt_q[p] <= '0;
        end else if (done && cnt_q[grant_q] != 16'hFFFF) begin
            cnt_q[grant_q] <= cnt_q[grant_q] + 16'd1;
        end
    end

    always_comb begin
        count_flat = '0;
        for (int p = 0; p < PORTS; p++) count_flat[16*p +: 16] = cnt_q[p];
    end
`else
    assign count_flat = '0;
`endif

endmodule

// File: tb/tb_random_arbiter.sv
// Self-checking bench for random_arbiter: directed vector table, corner-case sequences,
// and randomized traffic scored against a transaction-level reference model.
module tb_random_arbiter;
    localparam int PORTS = 4;
    localparam int BITS  = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [BITS-1:0]     in_data;
    logic [PORTS-1:0]    req;
    logic [PORTS-1:0]    out_valid;
    logic [BITS-1:0]     out_data;
    logic [PORTS*16-1:0] count_flat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    random_arbiter #(.PORTS(PORTS), .BITS(BITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .req        (req),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .count_flat (count_flat)
    );

    // Reference model: 0 = no word held, 1 = word held unassigned, 2 = word offered.
    int         m_phase;
    int         m_ptr;
    int         m_grant;
    logic [7:0] m_hold;
    int         m_cnt [PORTS];
    logic [7:0] delivered [$];
    logic [3:0] dut_fire;
    logic [7:0] dut_word;

    typedef struct {
        bit         v;
        logic [7:0] d;
        logic [3:0] r;
        bit         ir;
        logic [3:0] ov;
        logic [7:0] od;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_ptr   = 0;
        m_grant = 0;
        m_hold  = '0;
        for (int p = 0; p < PORTS; p++) m_cnt[p] = 0;
    endtask

    function automatic logic [63:0] exp_count();
        logic [63:0] e = '0;
`ifdef RANDOM_ARBITER_COUNT_EN
        for (int p = 0; p < PORTS; p++) e[16*p +: 16] = 16'(m_cnt[p]);
`endif
        return e;
    endfunction

    task automatic model_edge(input bit rs, input bit v, input logic [7:0] d, input logic [3:0] r);
        if (rs) begin
            model_reset();
            return;
        end
        case (m_phase)
            0: if (v) begin
                m_hold  = d;
                m_phase = 1;
            end
            1: if (r != 0) begin
                for (int k = 0; k < PORTS; k++) begin
                    if (((r >> ((m_ptr + k) % PORTS)) & 4'd1) != 0) begin
                        m_grant = (m_ptr + k) % PORTS;
                        break;
                    end
                end
                m_phase = 2;
            end
            default: if (((r >> m_grant) & 4'd1) != 0) begin
                m_ptr = (m_grant + 1) % PORTS;
                if (m_cnt[m_grant] < 65535) m_cnt[m_grant]++;
                m_phase = 0;
            end
        endcase
    endtask

    // One clock: delivery check before the edge, state checks just after it.
    task automatic tick();
        bit         rs;
        bit         v;
        logic [7:0] d;
        logic [3:0] r;
        logic [3:0] mfire;
        @(negedge clk);
        rs = rst;
        v  = in_valid;
        d  = in_data;
        r  = req;
        mfire = (!rs && m_phase == 2 && ((r >> m_grant) & 4'd1) != 0) ? 4'(1 << m_grant) : 4'b0;
        dut_fire = out_valid & req;
        dut_word = out_data;
        check("delivery", dut_fire, mfire);
        if (mfire != 0) delivered.push_back(m_hold);
        @(posedge clk);
        model_edge(rs, v, d, r);
        #1;
        check("in_ready", in_ready, (m_phase == 0 && !rst));
        check("out_valid", out_valid, (m_phase == 2) ? 4'(1 << m_grant) : 4'b0);
        check("out_data", out_data, m_hold);
        check("count_flat", count_flat, exp_count());
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        req = '0;
        tick();
        rst = 1'b0;
    endtask

    function automatic int port_of(input logic [3:0] oh);
        for (int p = 0; p < PORTS; p++) if (oh[p]) return p;
        return -1;
    endfunction

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int p;
        int last [PORTS];
        bit seen;

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        req = '0;
        model_reset();
        #1;
        check("rst_ready", in_ready, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_count", count_flat, 0);
        tick();
        tick();
        rst = 1'b0;

        // Pre-edge expectations for each row; ptr starts at 0.
        tbl[0]  = '{1'b1, 8'hA5, 4'b0100, 1'b1, 4'b0000, 8'h00};
        tbl[1]  = '{1'b0, 8'h00, 4'b0100, 1'b0, 4'b0000, 8'hA5};
        tbl[2]  = '{1'b0, 8'h00, 4'b0100, 1'b0, 4'b0100, 8'hA5};
        tbl[3]  = '{1'b1, 8'h5A, 4'b0000, 1'b1, 4'b0000, 8'hA5};
        tbl[4]  = '{1'b0, 8'h00, 4'b1001, 1'b0, 4'b0000, 8'h5A};
        tbl[5]  = '{1'b0, 8'h00, 4'b1001, 1'b0, 4'b1000, 8'h5A};
        tbl[6]  = '{1'b1, 8'hC3, 4'b0011, 1'b1, 4'b0000, 8'h5A};
        tbl[7]  = '{1'b0, 8'h00, 4'b0011, 1'b0, 4'b0000, 8'hC3};
        tbl[8]  = '{1'b0, 8'h00, 4'b0010, 1'b0, 4'b0001, 8'hC3};
        tbl[9]  = '{1'b0, 8'h00, 4'b0001, 1'b0, 4'b0001, 8'hC3};
        tbl[10] = '{1'b0, 8'h00, 4'b0000, 1'b1, 4'b0000, 8'hC3};
        for (int i = 0; i < 11; i++) begin
            in_valid = tbl[i].v;
            in_data  = tbl[i].d;
            req      = tbl[i].r;
            #1;
            check("tbl_ready", in_ready, tbl[i].ir);
            check("tbl_valid", out_valid, tbl[i].ov);
            check("tbl_data", out_data, tbl[i].od);
            tick();
        end

        // All ports requesting: grants rotate and each port sees its words in order.
        do_reset();
        req = 4'hF;
        in_valid = 1'b1;
        n = 0;
        for (int q = 0; q < PORTS; q++) last[q] = -1;
        for (int c = 0; c < 60 && n < 8; c++) begin
            in_data = 8'(c + 1);
            tick();
            if (dut_fire != 0) begin
                p = port_of(dut_fire);
                check("rr_grant", p, n % PORTS);
                check("rr_order", (int'(dut_word) > last[p]), 1);
                last[p] = int'(dut_word);
                n++;
            end
        end
        check("rr_count", n, 8);

        // Word parked in ARB with no requesters.
        do_reset();
        in_valid = 1'b1;
        in_data = 8'h77;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("arb_ready", in_ready, 0);
            check("arb_valid", out_valid, 0);
        end
        req = 4'b0010;
        tick();
        check("arb_grant", out_valid, 4'b0010);
        tick();
        req = '0;

        // Granted port drops its request while another port requests.
        do_reset();
        in_valid = 1'b1;
        in_data = 8'h99;
        req = 4'b0100;
        tick();
        in_valid = 1'b0;
        tick();
        req = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("stall_valid", out_valid, 4'b0100);
            check("stall_data", out_data, 8'h99);
        end
        req = 4'b0101;
        tick();
        check("stall_done_ready", in_ready, 1);
        check("stall_done_valid", out_valid, 0);
        req = '0;

        // Reset mid-offer discards the held word.
        do_reset();
        in_valid = 1'b1;
        in_data = 8'h3C;
        req = '0;
        tick();
        in_valid = 1'b0;
        req = 4'b1000;
        tick();
        req = '0;
        check("pre_rst_offer", out_valid, 4'b1000);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_data", out_data, 0);
        check("async_rst_ready", in_ready, 0);
        model_reset();
        delivered.delete();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            in_valid = 1'b1;
            in_data = 8'($urandom_range(0, 59));
            req = 4'($urandom_range(0, 15));
            tick();
        end
        seen = 1'b0;
        foreach (delivered[k]) if (delivered[k] == 8'h3C) seen = 1'b1;
        check("no_3c_after_rst", seen, 0);

        // Randomized traffic with occasional asynchronous resets.
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_data = 8'($urandom);
            req = ($urandom_range(0, 4) == 0) ? 4'b0 : 4'($urandom);
            tick();
        end
        rst = 1'b0;

`ifdef RANDOM_ARBITER_COUNT_EN
        do_reset();
        in_valid = 1'b1;
        req = 4'b0001;
        for (int c = 0; c < 70000 * 3 + 3; c++) tick();
        check("count_saturate", count_flat[15:0], 16'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
